// File: rtl/bist_seq_ctrl.sv
// BIST session sequencer: arms a pattern generator, compacts its data stream
// into a MISR per phase and compares each phase against an expected signature.
module bist_seq_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LEN_W      = 16,
  parameter logic [DATA_WIDTH-1:0] POLY       = 32'h04C11DB7,
  parameter int                    TMO        = 64,
  parameter int                    GAP_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [LEN_W-1:0]      run_len,
  input  logic [DATA_WIDTH-1:0] exp_sig0,
  input  logic [DATA_WIDTH-1:0] exp_sig1,
  output logic                  bist_enable,
  output logic                  bist_pattern_sel,
  output logic                  bist_capture_start,
  input  logic [DATA_WIDTH-1:0] bist_data,
  input  logic                  bist_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [DATA_WIDTH-1:0] signature,
  output logic                  err_timeout
);

  localparam int TW = $clog2(TMO + 2);
  localparam int GW = $clog2(GAP_CYC + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CHECK,
    S_GAP,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0] exp0_q, exp0_d;
  logic [DATA_WIDTH-1:0] exp1_q, exp1_d;
  logic [DATA_WIDTH-1:0] misr_q, misr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  phase_q, phase_d;
  logic                  fail_q, fail_d;
  logic                  rdy_q;

  logic                  en_q, en_d;
  logic                  sel_q, sel_d;
  logic                  cap_q, cap_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [DATA_WIDTH-1:0] sig_q, sig_d;
  logic                  tmo_q, tmo_d;

  function automatic logic [DATA_WIDTH-1:0] misr_step(input logic [DATA_WIDTH-1:0] m,
                                                      input logic [DATA_WIDTH-1:0] d);
    return ({m[DATA_WIDTH-2:0], 1'b0} ^ (m[DATA_WIDTH-1] ? POLY : '0)) ^ d;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (&c) ? c : c + LEN_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    exp0_d  = exp0_q;
    exp1_d  = exp1_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        // rdy_q masks the first edge after reset release
        if (start && !abort && rdy_q) begin
          mode_d  = (mode == 2'b11) ? 2'b00 : mode;
          len_d   = run_len;
          exp0_d  = exp_sig0;
          exp1_d  = exp_sig1;
          misr_d  = '0;
          cnt_d   = '0;
          idle_d  = '0;
          gap_d   = '0;
          phase_d = 1'b0;
          fail_d  = 1'b0;
          pass_d  = 1'b0;
          sig_d   = '0;
          tmo_d   = 1'b0;
          state_d = (run_len == '0) ? S_FIN : S_ARM;
        end
      end
      S_ARM: begin
        idle_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bist_valid) begin
          misr_d = misr_step(misr_q, bist_data);
          cnt_d  = sat_inc(cnt_q);
          idle_d = '0;
          if (cnt_d == len_q) state_d = S_CHECK;
        end else if (idle_q >= TW'(TMO - 1)) begin
          tmo_d   = 1'b1;
          fail_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (misr_q != (phase_q ? exp1_q : exp0_q)) fail_d = 1'b1;
        sig_d   = misr_q;
        gap_d   = '0;
        state_d = (mode_q == 2'b10 && !phase_q) ? S_GAP : S_FIN;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_d >= GW'(GAP_CYC)) begin
          phase_d = 1'b1;
          misr_d  = '0;
          cnt_d   = '0;
          state_d = S_ARM;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every other transition; FIN is already on its way out.
    if (abort && state_q != S_IDLE && state_q != S_FIN) begin
      state_d = S_FIN;
      fail_d  = 1'b1;
      tmo_d   = tmo_q;
      sig_d   = sig_q;
    end

    en_d   = (state_d == S_RUN);
    cap_d  = (state_d == S_ARM);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    sel_d  = (state_d == S_ARM || state_d == S_RUN) ? (phase_d | (mode_d == 2'b01)) : 1'b0;
    if (state_d == S_FIN && state_q != S_FIN) pass_d = ~fail_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      exp0_q  <= '0;
      exp1_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      gap_q   <= '0;
      phase_q <= 1'b0;
      fail_q  <= 1'b0;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      exp0_q  <= exp0_d;
      exp1_q  <= exp1_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
      fail_q  <= fail_d;
      rdy_q   <= 1'b1;
      en_q    <= en_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bist_enable        = en_q;
  assign bist_pattern_sel   = sel_q;
  assign bist_capture_start = cap_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign signature          = sig_q;
  assign err_timeout        = tmo_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Bench for bist_seq_ctrl: directed corner sessions plus randomized sessions
// scored against a signature/pass model computed from the session rules.
module tb_bist_seq_ctrl;

  localparam int          DW      = 32;
  localparam int          LW      = 16;
  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam int          TMO     = 64;
  localparam int          GAP_CYC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [1:0]    mode;
  logic [LW-1:0] run_len;
  logic [DW-1:0] exp_sig0, exp_sig1;
  logic          bist_enable, bist_pattern_sel, bist_capture_start;
  logic [DW-1:0] bist_data;
  logic          bist_valid;
  logic          busy, done, pass, err_timeout;
  logic [DW-1:0] signature;

  int checks   = 0;
  int failures = 0;

  logic [31:0] dat0 [64];
  logic [31:0] dat1 [64];

  always #5 clk = ~clk;

  bist_seq_ctrl #(
    .DATA_WIDTH(DW), .LEN_W(LW), .POLY(POLY), .TMO(TMO), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .run_len(run_len), .exp_sig0(exp_sig0), .exp_sig1(exp_sig1),
    .bist_enable(bist_enable), .bist_pattern_sel(bist_pattern_sel),
    .bist_capture_start(bist_capture_start), .bist_data(bist_data),
    .bist_valid(bist_valid), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature of a phase: multiply running value by x modulo POLY, then add the word.
  function automatic logic [31:0] model_sig(input int ph, input int n);
    logic [32:0] t;
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, m} * 33'd2;
      m = t[31:0] ^ (t[32] ? POLY : 32'h0) ^ (ph != 0 ? dat1[i] : dat0[i]);
    end
    return m;
  endfunction

  function automatic logic [7:0] outs();
    return {1'b0, bist_enable, bist_pattern_sel, bist_capture_start, busy, done, pass, err_timeout};
  endfunction

  task automatic do_session(input logic [1:0] m, input int len, input logic [31:0] e0,
                            input logic [31:0] e1, input bit starve, input bit poke);
    int phases, arms, sent, gapc, en_cyc, phase;
    bit seen_done, sel_bad, exp_pass, sel0;
    logic [31:0] sg0, sg1;
    phases   = (m == 2'b10) ? 2 : 1;
    sel0     = (m == 2'b01);
    sg0      = model_sig(0, len);
    sg1      = model_sig(1, len);
    exp_pass = !starve && (sg0 == e0) && (phases == 1 || sg1 == e1);
    @(negedge clk);
    mode = m; run_len = LW'(len); exp_sig0 = e0; exp_sig1 = e1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      chk("zl_done", {31'h0, done}, 32'h1);
      chk("zl_pass", {31'h0, pass}, 32'h1);
      chk("zl_busy", {31'h0, busy}, 32'h1);
      chk("zl_en_cap", {30'h0, bist_enable, bist_capture_start}, 32'h0);
      @(negedge clk);
      chk("zl_after", {30'h0, done, busy}, 32'h0);
      chk("zl_en_after", {31'h0, bist_enable}, 32'h0);
      return;
    end
    chk("lat_busy", {31'h0, busy}, 32'h1);
    chk("lat_arm", {31'h0, bist_capture_start}, 32'h1);
    chk("arm_sel0", {31'h0, bist_pattern_sel}, {31'h0, sel0});
    arms = 1; sent = 0; gapc = 0; en_cyc = 0; phase = 0; seen_done = 0; sel_bad = 0;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (bist_enable) begin
        en_cyc++;
        if (bist_pattern_sel !== (phase != 0 ? 1'b1 : sel0)) sel_bad = 1;
        if (!starve && ($urandom % 3) != 0) begin
          bist_valid = 1'b1;
          bist_data  = (phase != 0) ? dat1[sent] : dat0[sent];
          sent++;
        end else begin
          bist_valid = 1'b0;
          bist_data  = $urandom;
        end
      end else begin
        bist_valid = (($urandom % 4) == 0);
        bist_data  = $urandom;
      end
      start = poke && busy && (($urandom % 5) == 0);
      @(negedge clk);
      if (bist_capture_start) begin
        chk("gap_cycles", gapc, 1 + GAP_CYC);
        chk("arm_sel1", {31'h0, bist_pattern_sel}, 32'h1);
        arms++; phase = 1; sent = 0;
      end else if (busy && !bist_enable && !done && en_cyc > 0 && arms == 1) begin
        gapc++;
      end
      if (done) seen_done = 1;
    end
    start = 1'b0; bist_valid = 1'b0;
    chk("done_seen", {31'h0, seen_done}, 32'h1);
    if (seen_done) begin
      chk("pass", {31'h0, pass}, {31'h0, exp_pass});
      chk("err_timeout", {31'h0, err_timeout}, {31'h0, starve});
      chk("arms", arms, starve ? 1 : phases);
      chk("sel_run", {31'h0, sel_bad}, 32'h0);
      if (starve) chk("tmo_cycles", en_cyc, TMO);
      else chk("signature", signature, (phases == 2) ? sg1 : sg0);
      @(negedge clk);
      chk("done_1cyc", {31'h0, done}, 32'h0);
      chk("idle_after", {31'h0, busy}, 32'h0);
      chk("hold_pass", {31'h0, pass}, {31'h0, exp_pass});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; mode = 2'b00; run_len = 16'd1;
    exp_sig0 = 32'h0; exp_sig1 = 32'h0; bist_data = 32'h0; bist_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {24'h0, outs()}, 32'h0);
    chk("reset_sig", signature, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_ignored", {31'h0, busy}, 32'h0);
    start = 1'b0;

    // single phase, one beat
    dat0[0] = 32'h5;
    do_session(2'b00, 1, 32'h5, 32'h0, 0, 0);

    // two phases, phase 1 signature wrong
    dat0[0] = 32'h8000_0000; dat0[1] = 32'h0;
    dat1[0] = $urandom; dat1[1] = $urandom;
    chk("model_ref", model_sig(0, 2), 32'h04C11DB7);
    do_session(2'b10, 2, 32'h04C11DB7, model_sig(1, 2) ^ 32'h1, 0, 0);

    // zero length
    do_session(2'b00, 0, 32'h0, 32'h0, 0, 0);

    // start together with abort in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1; run_len = 16'd3;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {31'h0, busy}, 32'h0);

    // timeout
    do_session(2'b00, 4, 32'h0, 32'h0, 1, 0);

    // abort mid-RUN
    for (int i = 0; i < 8; i++) dat0[i] = $urandom;
    @(negedge clk); mode = 2'b00; run_len = 16'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("abort_in_run", {31'h0, bist_enable}, 32'h1);
    bist_valid = 1'b1; bist_data = dat0[0];
    @(negedge clk); bist_valid = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_en", {31'h0, bist_enable}, 32'h0);
    chk("abort_done", {30'h0, done, pass}, 32'h2);
    @(negedge clk);
    chk("abort_idle", {31'h0, busy}, 32'h0);

    // reset mid-RUN
    @(negedge clk); mode = 2'b10; run_len = 16'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); bist_valid = 1'b1; bist_data = 32'hDEAD_BEEF;
    @(negedge clk); bist_valid = 1'b0;
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {24'h0, outs()}, 32'h0);
    chk("async_reset_sig", signature, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // randomized sessions with start pokes while busy
    for (int s = 0; s < 12; s++) begin
      logic [1:0]  rm;
      int          rl;
      logic [31:0] r0, r1;
      rm = 2'($urandom % 4);
      rl = 1 + int'($urandom % 6);
      for (int i = 0; i < rl; i++) begin dat0[i] = $urandom; dat1[i] = $urandom; end
      r0 = model_sig(0, rl);
      r1 = model_sig(1, rl);
      if (($urandom % 4) == 0) r0 = r0 ^ (32'h1 << ($urandom % 32));
      if (($urandom % 4) == 0) r1 = r1 ^ (32'h1 << ($urandom % 32));
      do_session(rm, rl, r0, r1, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_seq_ctrl.md
BIST_SEQ_CTRL -- requirements
Module: bist_seq_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 32, pattern/signature width.
- LEN_W, 16, beat-count width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- TMO, 64, maximum idle cycles between valid beats.
- GAP_CYC, 2, enable-low cycles between phases.
REQ-002 SHALL have ports, one per line:
- clk in 1: single clock, rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- start in 1: session start pulse.
- abort in 1: session abort.
- mode in 2: 00 = pattern0 only, 01 = pattern1 only, 10 = pattern0 then pattern1, 11 = treated as 00.
- run_len in LEN_W: valid beats per phase.
- exp_sig0 in DATA_WIDTH: expected phase-0 signature.
- exp_sig1 in DATA_WIDTH: expected phase-1 signature.
- bist_enable out 1: enable to BIST generator.
- bist_pattern_sel out 1: pattern select to BIST generator.
- bist_capture_start out 1: capture arm to BIST generator.
- bist_data in DATA_WIDTH: BIST data_out.
- bist_valid in 1: BIST valid_out.
- busy out 1: session active.
- done out 1: one-cycle completion pulse.
- pass out 1: session result.
- signature out DATA_WIDTH: last computed MISR value.
- err_timeout out 1: session ended on timeout.
REQ-003 SHALL register all outputs; no combinational input-to-output paths.

Function
REQ-004 SHALL implement FSM states IDLE, ARM, RUN, CHECK, GAP, FIN.
REQ-005 IDLE: start=1 and abort=0 SHALL latch mode, run_len, exp_sig0 and exp_sig1; SHALL clear MISR, beat counter, fail flag and err_timeout; SHALL go to ARM. If the latched run_len==0, SHALL go to FIN instead.
REQ-006 ARM: bist_capture_start=1 and busy=1 for exactly one cycle; bist_pattern_sel set to the phase pattern (phase 0 -> mode[0] for modes 00/01, 0 for mode 10; phase 1 -> 1); next state RUN.
REQ-007 RUN: bist_enable=1. Each cycle with bist_valid=1, MISR <= ({MISR[W-2:0],1'b0} ^ (MISR[W-1] ? POLY : 0)) ^ bist_data, and the beat counter increments.
REQ-008 On the beat where the count reaches run_len, SHALL drop bist_enable at the next edge and go to CHECK. bist_valid outside RUN SHALL be ignored.
REQ-009 RUN timeout: TMO consecutive cycles with bist_valid=0 SHALL set err_timeout=1 and the fail flag, and go to FIN.
REQ-010 CHECK (one cycle): MISR != expected signature of the current phase SHALL set the fail flag. signature SHALL be loaded with MISR.
REQ-011 From CHECK: mode==10 and phase 0 -> GAP; otherwise -> FIN.
REQ-012 GAP: bist_enable=0 for GAP_CYC cycles; then phase=1, MISR and beat counter cleared, next state ARM.
REQ-013 FIN: done=1 for one cycle, pass = ~fail flag, busy=0 on exit; next state IDLE. pass, signature and err_timeout SHALL hold until the next accepted start.
REQ-014 abort=1 in any state other than IDLE SHALL force FIN at the next edge with pass=0, bist_enable=0 and bist_capture_start=0. abort takes priority over all other transitions.
REQ-015 start while busy SHALL be ignored. start and abort together in IDLE SHALL be ignored.
REQ-016 Latency: start sampled at edge k gives busy=1 and ARM at k+1, and bist_enable=1 at k+2.
REQ-017 Beat counter SHALL saturate and never wrap. MISR arithmetic is modulo 2^DATA_WIDTH.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE with all outputs 0, including signature, MISR, counters and phase; this applies mid-session.
REQ-019 After rst_n deasserts, the first start SHALL be accepted no earlier than the second rising edge.

Verification
REQ-020 Single phase: mode=00, run_len=1, bist_data=32'h5 on one valid beat, exp_sig0=32'h5 -> signature=32'h5, pass=1, done pulse, bist_pattern_sel=0 throughout.
REQ-021 Mismatch, two phases: mode=10, run_len=2, data 32'h8000_0000 then 32'h0, exp_sig0=32'h04C11DB7 -> phase 0 passes. Then exactly GAP_CYC enable-low cycles, ARM with pattern_sel=1; a wrong exp_sig1 -> pass=0.
REQ-022 Zero length: run_len=0, start -> FIN next cycle, pass=1, bist_enable never asserted.
REQ-023 Timeout: RUN with bist_valid held 0 -> err_timeout=1, pass=0 after TMO cycles, done pulse.
REQ-024 Abort and reset: abort mid-RUN -> bist_enable=0 next edge and done with pass=0; rst_n low mid-RUN -> all outputs 0 immediately; start while busy -> no restart.
